// File: rtl/viterbi_ctrl.sv
// Viterbi decoder frame controller: sequences ACS updates, traceback and frame completion.
// Optional path-metric normalization is enabled by defining VITERBI_NORM_EN.
module viterbi_ctrl #(
  parameter int FRAME_LEN = 32,
  parameter int PM_W      = 7,
  parameter int NORM_TH   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sym_valid,
  output logic            sym_ready,
  output logic            acs_en,
  input  logic [PM_W-1:0] pm_min,
  output logic            norm_en,
  output logic [PM_W-1:0] norm_val,
  output logic            ovf,
  output logic [7:0]      step_cnt,
  output logic            tb_start,
  input  logic            tb_done,
  output logic            frame_done,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACS   = 2'd1,
    TRACE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0]    LAST_STEP = 8'(FRAME_LEN - 1);
  // One extra bit so a threshold of exactly 2**PM_W never matches.
  localparam logic [PM_W:0] NORM_TH_W = (PM_W + 1)'(NORM_TH);

  state_t state;
  state_t state_next;
  logic   handshake;
  logic   last_step;
  logic   over_th;
  logic   trace_first;

  assign handshake = sym_valid & sym_ready;
  assign last_step = (step_cnt == LAST_STEP);
  assign over_th   = ({1'b0, pm_min} >= NORM_TH_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACS;
      ACS:     if (handshake && last_step) state_next = TRACE;
      TRACE:   if (tb_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sym_ready  = 1'b0;
    tb_start   = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE:    busy       = 1'b0;
      ACS:     sym_ready  = 1'b1;
      TRACE:   tb_start   = trace_first;
      DONE:    frame_done = 1'b1;
      default: busy       = 1'b0;
    endcase
  end

  assign acs_en = handshake;

  // Counter points at the step about to be processed; wraps to 0 on the frame's last step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_cnt <= 8'd0;
    end else if (state == IDLE && start) begin
      step_cnt <= 8'd0;
    end else if (handshake) begin
      step_cnt <= last_step ? 8'd0 : step_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trace_first <= 1'b0;
    end else begin
      trace_first <= (state == ACS) && (state_next == TRACE);
    end
  end

`ifdef VITERBI_NORM_EN
  logic            norm_pending;
  logic [PM_W-1:0] norm_amount;

  // A fresh threshold crossing takes priority over consuming an older request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      norm_pending <= 1'b0;
      norm_amount  <= '0;
    end else if (state == DONE) begin
      norm_pending <= 1'b0;
    end else if (handshake) begin
      if (over_th) begin
        norm_pending <= 1'b1;
        norm_amount  <= pm_min;
      end else begin
        norm_pending <= 1'b0;
      end
    end
  end

  assign norm_en  = acs_en & norm_pending;
  assign norm_val = norm_amount;
  assign ovf      = 1'b0;
`else
  logic ovf_flag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_flag <= 1'b0;
    end else if (handshake && over_th) begin
      ovf_flag <= 1'b1;
    end
  end

  assign norm_en  = 1'b0;
  assign norm_val = '0;
  assign ovf      = ovf_flag;
`endif

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Self-checking bench for viterbi_ctrl: directed frame scenarios followed by randomized traffic,
// all compared every cycle against a frame-level behavioural model.
module tb_viterbi_ctrl;

  localparam int FRAME_LEN = 32;
  localparam int PM_W      = 7;
  localparam int NORM_TH   = 64;

  logic            clk;
  logic            rst;
  logic            start;
  logic            sym_valid;
  logic            sym_ready;
  logic            acs_en;
  logic [PM_W-1:0] pm_min;
  logic            norm_en;
  logic [PM_W-1:0] norm_val;
  logic            ovf;
  logic [7:0]      step_cnt;
  logic            tb_start;
  logic            tb_done;
  logic            frame_done;
  logic            busy;

  int total;
  int bad;

  viterbi_ctrl #(
    .FRAME_LEN(FRAME_LEN),
    .PM_W     (PM_W),
    .NORM_TH  (NORM_TH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .acs_en    (acs_en),
    .pm_min    (pm_min),
    .norm_en   (norm_en),
    .norm_val  (norm_val),
    .ovf       (ovf),
    .step_cnt  (step_cnt),
    .tb_start  (tb_start),
    .tb_done   (tb_done),
    .frame_done(frame_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model: where we are in the frame, how many symbols consumed, cycles spent tracing.
  localparam int PH_IDLE = 0, PH_ACS = 1, PH_TRACE = 2, PH_DONE = 3;
  int mPhase;
  int mSteps;
  int mTraceAge;
  bit mOvf;
  bit mPend;
  int mNval;

  task automatic modelReset();
    mPhase    = PH_IDLE;
    mSteps    = 0;
    mTraceAge = 0;
    mOvf      = 1'b0;
    mPend     = 1'b0;
    mNval     = 0;
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit v, input int p, input bit d, input bit r);
    start     = s;
    sym_valid = v;
    pm_min    = PM_W'(p);
    tb_done   = d;
    rst       = r;
  endtask

  // Compare everything against the model for the current cycle, then advance the model one edge.
  task automatic checkOutput();
    bit expReady, expHs, expNormEn;
    int expNval;
    if (!rst) begin
      modelReset();
    end
    expReady  = rst && (mPhase == PH_ACS);
    expHs     = expReady && sym_valid;
`ifdef VITERBI_NORM_EN
    expNormEn = expHs && mPend;
    expNval   = mNval;
`else
    expNormEn = 1'b0;
    expNval   = 0;
`endif
    cmp("busy",       busy,       int'(mPhase != PH_IDLE));
    cmp("sym_ready",  sym_ready,  int'(expReady));
    cmp("acs_en",     acs_en,     int'(expHs));
    cmp("tb_start",   tb_start,   int'(mPhase == PH_TRACE && mTraceAge == 0));
    cmp("frame_done", frame_done, int'(mPhase == PH_DONE));
    cmp("step_cnt",   step_cnt,   mSteps);
    cmp("ovf",        ovf,        int'(mOvf));
    cmp("norm_en",    norm_en,    int'(expNormEn));
    cmp("norm_val",   norm_val,   expNval);
    if (!rst) return;
    case (mPhase)
      PH_IDLE: if (start) begin
        mPhase = PH_ACS;
        mSteps = 0;
      end
      PH_ACS: if (expHs) begin
`ifdef VITERBI_NORM_EN
        if (int'(pm_min) >= NORM_TH) begin
          mPend = 1'b1;
          mNval = int'(pm_min);
        end else begin
          mPend = 1'b0;
        end
`else
        if (int'(pm_min) >= NORM_TH) mOvf = 1'b1;
`endif
        mSteps++;
        if (mSteps == FRAME_LEN) begin
          mSteps    = 0;
          mPhase    = PH_TRACE;
          mTraceAge = 0;
        end
      end
      PH_TRACE: begin
        mTraceAge++;
        if (tb_done) mPhase = PH_DONE;
      end
      default: begin
        mPhase = PH_IDLE;
        mPend  = 1'b0;
      end
    endcase
  endtask

  task automatic cyc(input bit s, input bit v, input int p, input bit d, input bit r);
    @(posedge clk);
    #1;
    applyStimulus(s, v, p, d, r);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    modelReset();
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput();
    cmp("lit_reset_step", step_cnt, 0);
    cmp("lit_reset_busy", busy, 0);

    // Full frame with sym_valid held high, then traceback 3 cycles later.
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cmp("lit_idle_on_start", busy, 0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      cyc(0, 1, 10, 0, 1);
      cmp("lit_full_acs_en", acs_en, 1);
      cmp("lit_full_step", step_cnt, i);
    end
    cyc(0, 0, 0, 0, 1);
    cmp("lit_tb_start", tb_start, 1);
    cyc(0, 0, 0, 0, 1);
    cmp("lit_tb_start_once", tb_start, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cmp("lit_trace_wait", frame_done, 0);
    cyc(0, 0, 0, 0, 1);
    cmp("lit_frame_done", frame_done, 1);
    cyc(1, 0, 0, 0, 1);
    cmp("lit_frame_done_once", frame_done, 0);
    cmp("lit_idle_busy", busy, 0);
    cyc(0, 0, 0, 0, 1);
    cmp("lit_restart_ready", sym_ready, 1);

    // Toggled sym_valid: two handshakes.
    cyc(0, 1, 10, 0, 1);
    cmp("lit_tog_en1", acs_en, 1);
    cyc(0, 0, 10, 0, 1);
    cmp("lit_tog_en0", acs_en, 0);
    cyc(0, 1, 10, 0, 1);
    cyc(0, 0, 10, 0, 1);
    cmp("lit_tog_step", step_cnt, 2);

    // Metric over threshold on step 5.
    repeat (3) cyc(0, 1, 10, 0, 1);
    cyc(0, 1, 70, 0, 1);
    cmp("lit_step5", step_cnt, 5);
    cyc(0, 1, 10, 0, 1);
`ifdef VITERBI_NORM_EN
    cmp("lit_norm_en", norm_en, 1);
    cmp("lit_norm_val", norm_val, 70);
    cyc(0, 1, 10, 0, 1);
    cmp("lit_norm_once", norm_en, 0);
    cmp("lit_no_ovf", ovf, 0);
`else
    cmp("lit_ovf", ovf, 1);
    cmp("lit_norm_off", norm_en, 0);
    cyc(0, 1, 10, 0, 1);
    cmp("lit_ovf_sticky", ovf, 1);
`endif

    // Reset mid-frame at step 10.
    repeat (2) cyc(0, 1, 10, 0, 1);
    cyc(0, 1, 10, 0, 1);
    cmp("lit_step10", step_cnt, 10);
    cyc(0, 1, 10, 0, 0);
    cmp("lit_rst_step", step_cnt, 0);
    cmp("lit_rst_ready", sym_ready, 0);
    cmp("lit_rst_ovf", ovf, 0);
    cyc(0, 1, 10, 0, 1);
    cmp("lit_no_resume", busy, 0);
    cyc(1, 1, 10, 0, 1);
    cyc(0, 1, 10, 0, 1);
    cmp("lit_restart_step", step_cnt, 0);
    cmp("lit_restart_en", acs_en, 1);

    // Randomized traffic.
    for (int n = 0; n < 6000; n++) begin
      bit s, v, d, r;
      int p;
      s = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 399) != 0);
      p = ($urandom_range(0, 39) == 0) ? $urandom_range(NORM_TH, 127) : $urandom_range(0, NORM_TH - 1);
      cyc(s, v, p, d, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/viterbi_ctrl.md
VITERBI_CTRL -- requirements
Module: viterbi_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 32: trellis steps per frame, range 2..255.
REQ-002 Parameter PM_W, default 7: path-metric width, matching the ACS array.
REQ-003 Parameter NORM_TH, default 64: normalization threshold on pm_min.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  request to begin a frame; sampled only in IDLE.
REQ-007 sym_valid  in  1  branch-metric symbol available.
REQ-008 sym_ready  out  1  controller accepts a symbol this cycle.
REQ-009 acs_en  out  1  ACS array register-update enable.
REQ-010 pm_min  in  PM_W  minimum path metric from the ACS array.
REQ-011 norm_en  out  1  ACS array subtracts norm_val on this update.
REQ-012 norm_val  out  PM_W  amount to subtract from every path metric.
REQ-013 ovf  out  1  sticky path-metric overflow warning.
REQ-014 step_cnt  out  8  index of the next trellis step within the frame.
REQ-015 tb_start  out  1  one-cycle pulse that starts traceback.
REQ-016 tb_done  in  1  traceback unit has finished.
REQ-017 frame_done  out  1  one-cycle pulse marking frame completion.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have exactly four states, IDLE, ACS, TRACE and DONE, held in registers.
REQ-020 IDLE: sym_ready=0; if start=1, the FSM SHALL go to ACS next cycle and clear step_cnt to 0.
REQ-021 ACS: sym_ready=1, and a handshake is sym_valid & sym_ready in the same cycle.
REQ-022 acs_en SHALL equal the handshake combinationally, with zero latency.
REQ-023 Each handshake SHALL increment step_cnt by 1.
REQ-024 On the handshake with step_cnt==FRAME_LEN-1, the FSM SHALL go to TRACE and step_cnt SHALL wrap to 0.
REQ-025 tb_start SHALL be 1 for exactly the first cycle in TRACE.
REQ-026 TRACE: sym_ready=0; on tb_done=1, the FSM SHALL go to DONE, including when tb_done arrives in the tb_start cycle.
REQ-027 DONE: frame_done=1 for one cycle, then the FSM SHALL go to IDLE; start is ignored in DONE.
REQ-028 start outside IDLE and tb_done outside TRACE SHALL be ignored.
REQ-029 sym_valid deasserted in ACS SHALL stall the FSM, with step_cnt, acs_en and norm_en all held inactive.

Reset
REQ-030 Reset low SHALL force, asynchronously:
- FSM to IDLE, step_cnt=0, ovf=0;
- the norm pending flag cleared and norm_val=0;
- all pulse and handshake outputs to 0.
This applies in any state, including mid-frame.
REQ-031 After reset release, the first frame SHALL need a fresh start; no partial frame is resumed.

Configuration
REQ-032 With macro VITERBI_NORM_EN defined: a handshake with pm_min >= NORM_TH SHALL set a pending flag and capture pm_min into norm_val.
REQ-033 With VITERBI_NORM_EN defined: norm_en SHALL equal acs_en & pending, and the pending flag SHALL clear on that handshake.
REQ-034 With VITERBI_NORM_EN defined: the pending flag SHALL also clear on entry to IDLE, and ovf SHALL stay 0.
REQ-035 Without VITERBI_NORM_EN: norm_en=0 and norm_val=0 constantly.
REQ-036 Without VITERBI_NORM_EN: a handshake with pm_min >= NORM_TH SHALL set ovf, which stays set until reset.

Verification
REQ-037 Pulse start, then hold sym_valid=1 -> 32 consecutive acs_en cycles, step_cnt 0..31, tb_start one cycle after the 32nd handshake.
REQ-038 Drive tb_done 3 cycles after tb_start -> frame_done high for exactly one cycle, then busy=0, and a new start is accepted.
REQ-039 Toggle sym_valid 1,0,1,0 in ACS -> acs_en only on high cycles, and step_cnt advances 2.
REQ-040 With NORM_EN, pm_min=70 on step 5 -> norm_en=1 and norm_val=70 on step 6's handshake only; without it -> ovf=1, sticky.
REQ-041 Assert rst low at step 10 -> immediate IDLE, step_cnt=0, sym_ready=0; a start after release restarts at step 0.
